adder_acc_pipe: RTL and testbench
=================================

Name: adder_acc_pipe

Overview:
Parametrised, registered successor to the team's combinational two-input adder. Adds, subtracts or accumulates WIDTH-bit operands behind a valid/ready handshake, with one output register stage, carry/overflow flags, optional unsigned saturation and a wrapping transaction counter. Sits between operand producers and any consumer that can apply backpressure.

Parameters:
WIDTH, 8, operand/result width in bits (>=2).
SAT, 0, 1 = unsigned saturating result; 0 = wrap-around result.
CNT_W, 16, width of the transaction counter.

Ports:
clk  input  1  single clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B (ignored in modes 2, 3).
mode  input  2  0=add a+b, 1=sub a-b, 2=acc acc+a, 3=clear acc.
out_valid  output  1  result register holds an unconsumed result.
out_ready  input  1  consumer takes result this cycle.
sum  output  WIDTH  result.
carry  output  1  add/acc: raw carry-out; sub: 1 = no borrow (a>=b); clear: 0.
ovf  output  1  two's-complement signed overflow of the raw operation; clear: 0.
acc  output  WIDTH  current accumulator value.
txn_count  output  CNT_W  number of accepted beats, wraps at 2^CNT_W.

Behaviour:
- Reset (rst=1 at clock edge): out_valid=0, sum=0, carry=0, ovf=0, acc=0, txn_count=0. rst overrides any simultaneous transfer; an in-flight result is discarded.
- in_ready = !out_valid || out_ready (combinational; single-entry output stage, full throughput).
- Input transfer: in_valid && in_ready at the edge. Output transfer: out_valid && out_ready.
- Latency: 1 cycle. A beat accepted at edge N presents sum/carry/ovf with out_valid=1 after edge N.
- On output transfer with no new input: out_valid->0; sum/carry/ovf hold their last value.
- Simultaneous output and input transfer: out_valid stays 1, result register loads the new beat (back-to-back, no bubble).
- Stall (out_valid && !out_ready): sum, carry, ovf, out_valid held stable; in_ready=0; no beat accepted; acc unchanged.
- Arithmetic: computed at WIDTH+1 bits. raw = {carry, result[WIDTH-1:0]}.
  mode 0: a+b. mode 1: a + ~b + 1 (carry = no-borrow). mode 2: acc+a. mode 3: result 0, carry=0, ovf=0.
- ovf: add/acc: operands same sign, result sign differs; sub: operand signs differ, result sign differs from a.
- SAT=1: add/acc with carry=1 -> sum = all-ones; sub with borrow (carry=0) -> sum = 0. carry/ovf still report raw flags.
- acc: mode 2 accepted -> acc <= sum as registered (saturated if SAT=1); mode 3 accepted -> acc <= 0; modes 0/1 leave acc untouched. acc updates at the same edge as the result register.
- txn_count increments by 1 on every input transfer (all modes), wrapping from 2^CNT_W-1 to 0.
- Inputs a, b, mode sampled only on input transfer; changes while in_ready=0 have no effect.

Test Plan:
- Reset then idle: after rst, out_valid=0, sum=0, acc=0, txn_count=0, in_ready=1.
- WIDTH=8, SAT=0, out_ready=1: add 200+100 -> next cycle sum=44, carry=1, ovf=0. Sub 5-7 -> sum=254, carry=0. Add 100+100 -> sum=200, ovf=1.
- SAT=1: add 200+100 -> sum=255, carry=1. Sub 5-7 -> sum=0, carry=0.
- Accumulate: clear, then acc beats a=10, 20, 250 (SAT=0) -> sums 10, 30, 24; acc=24, last carry=1. Then mode 3 -> sum=0, acc=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> first result held, in_ready=0, acc and txn_count frozen. Release out_ready -> one beat per cycle, no loss or duplication. Then rst asserted mid-stream -> out_valid=0 next cycle.
- Counter wrap, CNT_W=4: 17 accepted beats -> txn_count=1.

Source files
------------

// File: rtl/adder_acc_pipe.sv
// Registered add/sub/accumulate unit with a valid/ready handshake, one output
// register stage, carry/overflow flags, optional unsigned saturation and a beat counter.
module adder_acc_pipe #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_ACC = 2'd2;
  localparam logic [1:0] MODE_CLR = 2'd3;

  logic             valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             ovf_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic             cin;
  logic [WIDTH:0]   raw;
  logic             raw_ovf;
  logic [WIDTH-1:0] sum_next;
  logic             carry_next;
  logic             ovf_next;
  logic [WIDTH-1:0] acc_next;

  // Single-entry output stage: a beat may enter whenever the slot is empty
  // or is being drained in the same cycle.
  assign in_ready = !valid_reg || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid_reg && out_ready;

  // One shared WIDTH+1 adder; subtraction is a + ~b + 1.
  always_comb begin
    lhs = a;
    rhs = b;
    cin = 1'b0;
    case (mode)
      MODE_SUB: begin
        rhs = ~b;
        cin = 1'b1;
      end
      MODE_ACC: begin
        lhs = acc_reg;
        rhs = a;
      end
      default: ;
    endcase
  end

  assign raw = {1'b0, lhs} + {1'b0, rhs} + {{WIDTH{1'b0}}, cin};

  // With rhs already inverted for subtraction, one same-sign rule covers all modes.
  assign raw_ovf = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (raw[WIDTH-1] != lhs[WIDTH-1]);

  generate
    if (SAT) begin : g_sat
      always_comb begin
        sum_next = raw[WIDTH-1:0];
        if ((mode == MODE_ADD || mode == MODE_ACC) && raw[WIDTH]) begin
          sum_next = {WIDTH{1'b1}};
        end else if (mode == MODE_SUB && !raw[WIDTH]) begin
          sum_next = {WIDTH{1'b0}};
        end
        if (mode == MODE_CLR) begin
          sum_next = {WIDTH{1'b0}};
        end
      end
    end else begin : g_wrap
      always_comb begin
        sum_next = raw[WIDTH-1:0];
        if (mode == MODE_CLR) begin
          sum_next = {WIDTH{1'b0}};
        end
      end
    end
  endgenerate

  always_comb begin
    carry_next = raw[WIDTH];
    ovf_next   = raw_ovf;
    if (mode == MODE_CLR) begin
      carry_next = 1'b0;
      ovf_next   = 1'b0;
    end
  end

  always_comb begin
    acc_next = acc_reg;
    case (mode)
      MODE_ACC: acc_next = sum_next;
      MODE_CLR: acc_next = {WIDTH{1'b0}};
      default:  acc_next = acc_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      sum_reg   <= {WIDTH{1'b0}};
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      acc_reg   <= {WIDTH{1'b0}};
      cnt_reg   <= {CNT_W{1'b0}};
    end else if (in_fire) begin
      valid_reg <= 1'b1;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      ovf_reg   <= ovf_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (out_fire) begin
      // Result fields keep their last value once consumed.
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign sum       = sum_reg;
  assign carry     = carry_reg;
  assign ovf       = ovf_reg;
  assign acc       = acc_reg;
  assign txn_count = cnt_reg;

endmodule

// File: tb/tb_adder_acc_pipe.sv
// Bench for adder_acc_pipe: a wrapping/4-bit-counter instance and a saturating instance
// share stimulus and are checked every cycle against an arithmetic model.
module tb_adder_acc_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] mode;

  logic        in_ready0, out_valid0, carry0, ovf0;
  logic [7:0]  sum0, acc0;
  logic [3:0]  txn0;
  logic        in_ready1, out_valid1, carry1, ovf1;
  logic [7:0]  sum1, acc1;
  logic [15:0] txn1;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  // model state, index 0 = wrap/CNT_W=4, index 1 = saturating/CNT_W=16
  logic       m_valid [2];
  logic [7:0] m_sum   [2];
  logic       m_carry [2];
  logic       m_ovf   [2];
  logic [7:0] m_acc   [2];
  int         m_cnt   [2];

  always #5 clk = ~clk;

  adder_acc_pipe #(.WIDTH(8), .SAT(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .carry(carry0), .ovf(ovf0), .acc(acc0), .txn_count(txn0)
  );

  adder_acc_pipe #(.WIDTH(8), .SAT(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .carry(carry1), .ovf(ovf1), .acc(acc1), .txn_count(txn1)
  );

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Specification arithmetic with plain integers.
  task automatic calc(input int sat, input int md, input int x, input int y, input int accv,
                      output logic [7:0] s, output logic c, output logic o);
    int lhs, rhs, r, sr;
    s = 8'd0; c = 1'b0; o = 1'b0;
    if (md == 0 || md == 2) begin
      lhs = (md == 2) ? accv : x;
      rhs = (md == 2) ? x : y;
      r   = lhs + rhs;
      sr  = sgn(lhs) + sgn(rhs);
      c   = (r > 255);
      o   = (sr > 127) || (sr < -128);
      s   = (sat != 0 && c) ? 8'd255 : 8'(r % 256);
    end else if (md == 1) begin
      r  = x - y + 256;
      sr = sgn(x) - sgn(y);
      c  = (x >= y);
      o  = (sr > 127) || (sr < -128);
      s  = (sat != 0 && !c) ? 8'd0 : 8'(r % 256);
    end
  endtask

  always @(posedge clk) begin
    logic [7:0] s;
    logic       c, o;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_valid[i] <= 1'b0; m_sum[i] <= 8'd0; m_carry[i] <= 1'b0;
        m_ovf[i] <= 1'b0; m_acc[i] <= 8'd0; m_cnt[i] <= 0;
      end else if (in_valid && (!m_valid[i] || out_ready)) begin
        calc(i, int'(mode), int'(a), int'(b), int'(m_acc[i]), s, c, o);
        m_valid[i] <= 1'b1; m_sum[i] <= s; m_carry[i] <= c; m_ovf[i] <= o;
        if (mode == 2'd2) m_acc[i] <= s;
        else if (mode == 2'd3) m_acc[i] <= 8'd0;
        m_cnt[i] <= (i == 0) ? (m_cnt[i] + 1) % 16 : (m_cnt[i] + 1) % 65536;
      end else if (m_valid[i] && out_ready) begin
        m_valid[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready0", int'(in_ready0), int'(!m_valid[0] || out_ready));
      cmp("out_valid0", int'(out_valid0), int'(m_valid[0]));
      cmp("sum0", int'(sum0), int'(m_sum[0]));
      cmp("carry0", int'(carry0), int'(m_carry[0]));
      cmp("ovf0", int'(ovf0), int'(m_ovf[0]));
      cmp("acc0", int'(acc0), int'(m_acc[0]));
      cmp("txn0", int'(txn0), m_cnt[0]);
      cmp("in_ready1", int'(in_ready1), int'(!m_valid[1] || out_ready));
      cmp("out_valid1", int'(out_valid1), int'(m_valid[1]));
      cmp("sum1", int'(sum1), int'(m_sum[1]));
      cmp("carry1", int'(carry1), int'(m_carry[1]));
      cmp("ovf1", int'(ovf1), int'(m_ovf[1]));
      cmp("acc1", int'(acc1), int'(m_acc[1]));
      cmp("txn1", int'(txn1), m_cnt[1]);
    end
  end

  // One accepted beat with out_ready=1; returns at the negedge after acceptance.
  task automatic beat(input logic [1:0] md, input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #2;
    mode = md; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    $display("beat mode=%0d a=%0d b=%0d -> sum0=%0d c0=%0d v0=%0d sum1=%0d acc0=%0d",
             md, x, y, sum0, carry0, ovf0, sum1, acc0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 8'd0; b = 8'd0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_out_valid", int'(out_valid0), 0);
    cmp("rst_sum", int'(sum0), 0);
    cmp("rst_acc", int'(acc0), 0);
    cmp("rst_txn", int'(txn0), 0);
    cmp("rst_in_ready", int'(in_ready0), 1);

    beat(2'd0, 8'd200, 8'd100);
    cmp("add_sum", int'(sum0), 44);
    cmp("add_carry", int'(carry0), 1);
    cmp("add_ovf", int'(ovf0), 0);
    cmp("add_sat_sum", int'(sum1), 255);
    cmp("add_sat_carry", int'(carry1), 1);
    beat(2'd1, 8'd5, 8'd7);
    cmp("sub_sum", int'(sum0), 254);
    cmp("sub_carry", int'(carry0), 0);
    cmp("sub_sat_sum", int'(sum1), 0);
    cmp("sub_sat_carry", int'(carry1), 0);
    beat(2'd0, 8'd100, 8'd100);
    cmp("ovf_sum", int'(sum0), 200);
    cmp("ovf_flag", int'(ovf0), 1);

    beat(2'd3, 8'd0, 8'd0);
    beat(2'd2, 8'd10, 8'd0);
    cmp("acc1_sum", int'(sum0), 10);
    beat(2'd2, 8'd20, 8'd0);
    cmp("acc2_sum", int'(sum0), 30);
    beat(2'd2, 8'd250, 8'd0);
    cmp("acc3_sum", int'(sum0), 24);
    cmp("acc3_acc", int'(acc0), 24);
    cmp("acc3_carry", int'(carry0), 1);
    cmp("acc3_sat_acc", int'(acc1), 255);
    beat(2'd3, 8'd9, 8'd9);
    cmp("clr_sum", int'(sum0), 0);
    cmp("clr_acc", int'(acc0), 0);

    // backpressure: first beat enters, then three stalled cycles
    @(posedge clk); #2;
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0; a = 8'd1; b = 8'd2;
    @(posedge clk); #2;
    a = 8'd50; mode = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp("bp_in_ready", int'(in_ready0), 0);
      cmp("bp_sum", int'(sum0), 3);
      cmp("bp_out_valid", int'(out_valid0), 1);
      cmp("bp_txn", int'(txn0), 9);
      cmp("bp_acc", int'(acc0), 0);
      $display("stall %0d: sum0=%0d in_ready0=%0d txn0=%0d", k, sum0, in_ready0, txn0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mode = 2'(k % 3); a = 8'(k * 37); b = 8'(k * 11);
      @(posedge clk); #2;
      $display("stream %0d: sum0=%0d out_valid0=%0d", k, sum0, out_valid0);
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    cmp("midrst_out_valid", int'(out_valid0), 0);

    @(posedge clk); #2;
    in_valid = 1'b1; mode = 2'd0;
    repeat (17) @(posedge clk);
    #2 in_valid = 1'b0;
    @(negedge clk);
    cmp("wrap_txn", int'(txn0), 1);
    cmp("wrap_txn16", int'(txn1), 17);
    $display("wrap: txn0=%0d txn1=%0d", txn0, txn1);

    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #2;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mode      = 2'($urandom_range(0, 3));
      a         = 8'($urandom);
      b         = 8'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
